// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: definitions shared by the memory arbiter and its grant selector.
//   - arb_state_e : arbiter FSM states (IDLE, SERVE_D, SERVE_I)
//   - grant_e     : grant encoding (GNT_D, GNT_I)
//   - ADDR_W_DEF / DATA_W_DEF : default block address / data widths
package cpu_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_D = 2'd1,
        SERVE_I = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_D = 1'b0,
        GNT_I = 1'b1
    } grant_e;

endpackage

// File: rtl/arb_priority_sel.sv
// arb_priority_sel: purely combinational grant selection for the memory arbiter.
// Ports:
//   d_req_i      - data cache requests (read or write)
//   i_req_i      - instruction cache requests (read)
//   last_grant_i - requester granted most recently
//   grant_o      - requester to serve next (only meaningful when a request is pending)
// Configuration macro MEM_ARBITER_ROUND_ROBIN_EN:
//   defined   - ties go to the requester not named by last_grant_i
//   undefined - ties always go to the data cache; last_grant_i is ignored
module arb_priority_sel
    import cpu_mem_pkg::*;
(
    input  logic   d_req_i,
    input  logic   i_req_i,
    input  grant_e last_grant_i,
    output grant_e grant_o
);

`ifndef MEM_ARBITER_ROUND_ROBIN_EN
    // Fixed priority has no use for history.
    grant_e unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

    always_comb begin
        grant_o = GNT_D;
        if (d_req_i && i_req_i) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            grant_o = (last_grant_i == GNT_D) ? GNT_I : GNT_D;
`else
            grant_o = GNT_D;
`endif
        end else if (i_req_i) begin
            grant_o = GNT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between a data cache (read/write) and an
// instruction cache (read-only).
// Ports:
//   CLK, RESET                      - clock, synchronous active-high reset
//   D_READ/D_WRITE/D_ADDRESS/D_WRITEDATA, D_READDATA, D_BUSYWAIT - data cache side
//   I_READ/I_ADDRESS, I_READDATA, I_BUSYWAIT                       - instruction cache side
//   MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA, MEM_READDATA, MEM_BUSYWAIT - memory side
// A granted requester's lines pass straight through to memory. A transaction is
// complete once memory has raised busywait (started) and then dropped it; the
// arbiter always spends one IDLE cycle between grants.
// Configuration macro MEM_ARBITER_ROUND_ROBIN_EN selects round-robin tie breaking
// (defined) or fixed data-cache priority (undefined, no LAST_GRANT register).
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    // Data cache
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [ADDR_W-1:0] D_ADDRESS,
    input  logic [DATA_W-1:0] D_WRITEDATA,
    output logic [DATA_W-1:0] D_READDATA,
    output logic              D_BUSYWAIT,
    // Instruction cache
    input  logic              I_READ,
    input  logic [ADDR_W-1:0] I_ADDRESS,
    output logic [DATA_W-1:0] I_READDATA,
    output logic              I_BUSYWAIT,
    // Memory
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT
);

    arb_state_e state_q;
    logic       started_q;
    grant_e     grant;
    grant_e     last_grant;

    logic d_req;
    logic i_req;
    logic gnt_req;
    logic serving_d;
    logic serving_i;
    logic done;

    assign d_req     = D_READ | D_WRITE;
    assign i_req     = I_READ;
    assign serving_d = (state_q == SERVE_D);
    assign serving_i = (state_q == SERVE_I);

    // Request of whichever side currently holds the grant.
    assign gnt_req = (serving_d & d_req) | (serving_i & i_req);
    assign done    = started_q & ~MEM_BUSYWAIT;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    grant_e last_grant_q;
    assign last_grant = last_grant_q;
`else
    assign last_grant = GNT_I;
`endif

    arb_priority_sel u_sel (
        .d_req_i      (d_req),
        .i_req_i      (i_req),
        .last_grant_i (last_grant),
        .grant_o      (grant)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_grant_q <= GNT_I;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    started_q <= 1'b0;
                    if (d_req || i_req) begin
                        state_q <= (grant == GNT_D) ? SERVE_D : SERVE_I;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                        last_grant_q <= grant;
`endif
                    end
                end
                SERVE_D, SERVE_I: begin
                    // Abort and completion both release the memory the same way.
                    if (!gnt_req || done) begin
                        state_q   <= IDLE;
                        started_q <= 1'b0;
                    end else if (MEM_BUSYWAIT) begin
                        started_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    started_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        case (state_q)
            SERVE_D: begin
                MEM_READ      = D_READ;
                MEM_WRITE     = D_WRITE;
                MEM_ADDRESS   = D_ADDRESS;
                MEM_WRITEDATA = D_WRITEDATA;
            end
            SERVE_I: begin
                MEM_READ    = I_READ;
                MEM_ADDRESS = I_ADDRESS;
            end
            default: ;
        endcase
        // Reset must silence memory immediately, not one edge later.
        if (RESET) begin
            MEM_READ  = 1'b0;
            MEM_WRITE = 1'b0;
        end
    end

    assign D_BUSYWAIT = d_req & ~(serving_d & done);
    assign I_BUSYWAIT = i_req & ~(serving_i & done);

    assign D_READDATA = MEM_READDATA;
    assign I_READDATA = MEM_READDATA;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory model.
module tb_mem_arbiter;

    localparam int AW  = 6;
    localparam int DW  = 32;
    localparam int LAT = 5;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          D_READ, D_WRITE, I_READ;
    logic [AW-1:0] D_ADDRESS, I_ADDRESS, MEM_ADDRESS;
    logic [DW-1:0] D_WRITEDATA, D_READDATA, I_READDATA, MEM_WRITEDATA, MEM_READDATA;
    logic          D_BUSYWAIT, I_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RESET(RESET),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS),
        .D_WRITEDATA(D_WRITEDATA), .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA),
        .I_BUSYWAIT(I_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    // Memory model: busy for LAT cycles after seeing a strobe, then one quiet
    // (done) cycle; dropping the strobes cancels an access in flight.
    logic [DW-1:0] mem [64];
    logic [63:0]   wr_vld   = '0;
    int            mem_cnt  = 0;
    logic          mem_done = 1'b0;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 6'h05) return 32'hA1B2C3D4;
        if (a == 6'h00) return 32'h00000100;
        return 32'h5A5A0000 | {26'h0, a};
    endfunction

    assign MEM_BUSYWAIT = (mem_cnt != 0);
    assign MEM_READDATA = wr_vld[MEM_ADDRESS] ? mem[MEM_ADDRESS] : init_val(MEM_ADDRESS);

    always @(posedge CLK) begin
        if (mem_cnt != 0) begin
            if (!(MEM_READ || MEM_WRITE)) begin
                mem_cnt <= 0;
            end else begin
                mem_cnt <= mem_cnt - 1;
                if (mem_cnt == 1) mem_done <= 1'b1;
            end
        end else if (mem_done) begin
            mem_done <= 1'b0;
        end else if (MEM_READ || MEM_WRITE) begin
            mem_cnt <= LAT;
            if (MEM_WRITE) begin
                mem[MEM_ADDRESS]    <= MEM_WRITEDATA;
                wr_vld[MEM_ADDRESS] <= 1'b1;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Step cycles until the chosen busywait falls (bounded), tracking the other one.
    task automatic wait_low(input bit use_d, output int cyc, output bit other_all,
                            output bit other_any);
        logic b, o;
        cyc       = 0;
        other_all = 1'b1;
        other_any = 1'b0;
        forever begin
            b = use_d ? D_BUSYWAIT : I_BUSYWAIT;
            o = use_d ? I_BUSYWAIT : D_BUSYWAIT;
            other_all &= o;
            other_any |= o;
            if (!b || cyc >= 30) break;
            tick();
            cyc++;
        end
    endtask

    task automatic pulse_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    int         cyc;
    bit         oall, oany;
    logic [5:0] exp_addr [3];

    initial begin
        RESET = 1'b1;
        D_READ = 0; D_WRITE = 0; I_READ = 0;
        D_ADDRESS = '0; I_ADDRESS = '0; D_WRITEDATA = '0;
        tick();
        tick();
        // Reset state
        check("rst_mem_read", MEM_READ, 0);
        check("rst_mem_write", MEM_WRITE, 0);
        check("rst_mem_addr", MEM_ADDRESS, 0);
        check("rst_mem_wdata", MEM_WRITEDATA, 0);
        check("rst_dbusy", D_BUSYWAIT, 0);
        check("rst_ibusy", I_BUSYWAIT, 0);
        D_READ = 1; #1;
        check("rst_dbusy_req", D_BUSYWAIT, 1);
        check("rst_mem_read_req", MEM_READ, 0);
        D_READ = 0;
        RESET  = 0;
        tick();

        // D-only read
        D_READ = 1; D_ADDRESS = 6'h05; #1;
        check("dr_idle_busy", D_BUSYWAIT, 1);
        check("dr_idle_mem_read", MEM_READ, 0);
        tick();
        check("dr_mem_read", MEM_READ, 1);
        check("dr_mem_write", MEM_WRITE, 0);
        check("dr_mem_addr", MEM_ADDRESS, 6'h05);
        wait_low(1'b1, cyc, oall, oany);
        check("dr_latency", cyc, 6);
        check("dr_rdata", D_READDATA, 32'hA1B2C3D4);
        check("dr_ibusy_any", oany, 0);
        tick();
        D_READ = 0; #1;
        check("dr_after_idle_read", MEM_READ, 0);
        check("dr_after_idle_addr", MEM_ADDRESS, 0);
        check("dr_after_dbusy", D_BUSYWAIT, 0);

        // Tie right after reset: D write first in either build
        pulse_reset();
        D_WRITE = 1; D_ADDRESS = 6'h02; D_WRITEDATA = 32'h00000202;
        I_READ = 1; I_ADDRESS = 6'h00; #1;
        check("tie_ibusy0", I_BUSYWAIT, 1);
        check("tie_dbusy0", D_BUSYWAIT, 1);
        tick();
        check("tie_mem_write", MEM_WRITE, 1);
        check("tie_mem_read", MEM_READ, 0);
        check("tie_mem_addr", MEM_ADDRESS, 6'h02);
        check("tie_mem_wdata", MEM_WRITEDATA, 32'h00000202);
        wait_low(1'b1, cyc, oall, oany);
        check("tie_d_latency", cyc, 6);
        check("tie_ibusy_held", oall, 1);
        tick();
        D_WRITE = 0; #1;
        check("tie_gap_read", MEM_READ, 0);
        check("tie_gap_write", MEM_WRITE, 0);
        check("tie_gap_ibusy", I_BUSYWAIT, 1);
        tick();
        check("tie_i_read", MEM_READ, 1);
        check("tie_i_addr", MEM_ADDRESS, 6'h00);
        wait_low(1'b0, cyc, oall, oany);
        check("tie_i_latency", cyc, 6);
        check("tie_i_rdata", I_READDATA, 32'h00000100);
        tick();
        I_READ = 0;
        D_READ = 1; D_ADDRESS = 6'h02;
        tick();
        wait_low(1'b1, cyc, oall, oany);
        check("rb_latency", cyc, 6);
        check("rb_rdata", D_READDATA, 32'h00000202);
        tick();
        D_READ = 0;

        // Three ties after reset
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        exp_addr[0] = 6'h11; exp_addr[1] = 6'h22; exp_addr[2] = 6'h11;
`else
        exp_addr[0] = 6'h11; exp_addr[1] = 6'h11; exp_addr[2] = 6'h11;
`endif
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            D_WRITE = 1; D_ADDRESS = 6'h11; D_WRITEDATA = 32'h11;
            I_READ = 1; I_ADDRESS = 6'h22;
            tick();
            check($sformatf("rr_grant%0d", k), MEM_ADDRESS, exp_addr[k]);
            D_WRITE = 0; I_READ = 0;
            tick();
        end

        // Reset in SERVE_I with STARTED set
        I_READ = 1; I_ADDRESS = 6'h07;
        tick();
        tick();
        tick();
        check("rm_mem_read", MEM_READ, 1);
        check("rm_ibusy", I_BUSYWAIT, 1);
        RESET = 1; #1;
        check("rm_read_forced", MEM_READ, 0);
        tick();
        RESET = 0; #1;
        check("rm_idle_read", MEM_READ, 0);
        check("rm_idle_addr", MEM_ADDRESS, 0);
        check("rm_no_completion", I_BUSYWAIT, 1);
        I_READ = 0;
        tick();

        // Abort D with an I request pending
        D_READ = 1; D_ADDRESS = 6'h05;
        tick();
        I_READ = 1; I_ADDRESS = 6'h09;
        tick();
        tick();
        check("ab_mem_read", MEM_READ, 1);
        check("ab_mem_addr", MEM_ADDRESS, 6'h05);
        D_READ = 0; #1;
        check("ab_read_drop", MEM_READ, 0);
        check("ab_dbusy", D_BUSYWAIT, 0);
        check("ab_ibusy", I_BUSYWAIT, 1);
        tick();
        check("ab_idle_read", MEM_READ, 0);
        check("ab_idle_addr", MEM_ADDRESS, 0);
        tick();
        check("ab_i_read", MEM_READ, 1);
        check("ab_i_addr", MEM_ADDRESS, 6'h09);
        wait_low(1'b0, cyc, oall, oany);
        check("ab_i_latency", cyc, 6);
        check("ab_i_rdata", I_READDATA, 32'h5A5A0009);
        tick();
        I_READ = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
